// File: rtl/vc8_vidram_arb.sv
// VC-8 video RAM port-B read arbiter and point-ring scan sequencer.
// One read in flight; ARM and scanner share the port round-robin.
module vc8_vidram_arb #(
  parameter int unsigned RDLAT = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armreq,
  input  logic [14:0] armaddr,
  output logic        armbusy,
  output logic        armdone,
  output logic [21:0] armdata,
  input  logic        scan_start,
  input  logic [14:0] scan_first,
  input  logic [14:0] scan_end,
  input  logic        scan_loop,
  input  logic        scan_abort,
  output logic        scanning,
  output logic        scan_done,
  output logic        pt_valid,
  output logic [21:0] pt_data,
  input  logic        pt_ready,
  output logic [14:0] vidaddrb,
  output logic        videnabb,
  input  logic [21:0] viddatab
);

  localparam logic [2:0] LAT = 3'(RDLAT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        own_scan_q, own_scan_d;
  logic [14:0] addr_q, addr_d;
  logic        prio_arm_q, prio_arm_d;

  logic        armbusy_q, armbusy_d;
  logic        arm_pend_q, arm_pend_d;
  logic [14:0] armaddr_q, armaddr_d;
  logic [21:0] armdata_q, armdata_d;
  logic        armdone_q, armdone_d;

  logic        scanning_q, scanning_d;
  logic        scan_done_q, scan_done_d;
  logic        pt_valid_q, pt_valid_d;
  logic [21:0] pt_data_q, pt_data_d;
  logic [14:0] ptr_q, ptr_d;
  logic        discard_q, discard_d;

  logic        arm_accept;
  logic        arm_act;
  logic [14:0] arm_gaddr;
  logic        scan_ctl;
  logic        scan_act;
  logic        gnt_arm;
  logic        gnt_scan;
  logic        cap;
  logic        cap_arm;
  logic        cap_scan;
  logic        scan_fly;
  logic        pass_end;
  logic        ring_empty;

  // Requests
  assign arm_accept = armreq && !armbusy_q;
  assign arm_act    = arm_pend_q || arm_accept;
  assign arm_gaddr  = arm_pend_q ? armaddr_q : armaddr;
  assign scan_ctl   = scan_start || scan_abort;
  assign ring_empty = (scan_first == scan_end);
  assign scan_act   = scanning_q && !pt_valid_q &&
                      (ptr_q != scan_end) && !scan_ctl;

  always_comb begin
    gnt_arm  = 1'b0;
    gnt_scan = 1'b0;
    if (state_q == S_IDLE) begin
      unique case (1'b1)
        arm_act && (!scan_act || prio_arm_q):
          gnt_arm = 1'b1;
        scan_act && (!arm_act || !prio_arm_q):
          gnt_scan = 1'b1;
        default: ;
      endcase
    end
  end

  // Read FSM: state register
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      own_scan_q <= 1'b0;
      addr_q     <= 15'd0;
      prio_arm_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_scan_q <= own_scan_d;
      addr_q     <= addr_d;
      prio_arm_q <= prio_arm_d;
    end
  end

  // Read FSM: next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_scan_d = own_scan_q;
    addr_d     = addr_q;
    prio_arm_d = prio_arm_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_arm || gnt_scan) begin
          state_d    = S_READ;
          cnt_d      = LAT;
          own_scan_d = gnt_scan;
          addr_d     = gnt_scan ? ptr_q : arm_gaddr;
          prio_arm_d = gnt_scan;
        end
      end
      S_READ: begin
        if (cnt_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    videnabb = (state_q == S_READ);
    cap      = videnabb && (cnt_q == 3'd0);
    cap_arm  = cap && !own_scan_q;
    scan_fly = videnabb && own_scan_q && !discard_q;
    cap_scan = cap && own_scan_q && !discard_q && !scan_ctl;
  end

  assign vidaddrb = addr_q;

  always_comb begin
    armbusy_d  = armbusy_q;
    arm_pend_d = arm_pend_q;
    armaddr_d  = armaddr_q;
    armdata_d  = armdata_q;
    armdone_d  = 1'b0;
    if (arm_accept) begin
      armbusy_d  = 1'b1;
      armaddr_d  = armaddr;
      arm_pend_d = !gnt_arm;
    end else if (gnt_arm) begin
      arm_pend_d = 1'b0;
    end
    if (cap_arm) begin
      armdata_d = viddatab;
      armbusy_d = 1'b0;
      armdone_d = 1'b1;
    end
  end

  assign pass_end = scanning_q && !pt_valid_q &&
                    (ptr_q == scan_end) && !scan_fly && !scan_ctl;

  always_comb begin
    scanning_d  = scanning_q;
    scan_done_d = 1'b0;
    pt_valid_d  = pt_valid_q;
    pt_data_d   = pt_data_q;
    ptr_d       = ptr_q;
    discard_d   = discard_q;
    if (pt_valid_q && pt_ready) begin
      pt_valid_d = 1'b0;
    end
    if (cap_scan) begin
      pt_data_d  = viddatab;
      pt_valid_d = 1'b1;
      ptr_d      = ptr_q + 15'd1;
    end
    if (cap) begin
      discard_d = 1'b0;
    end
    // An empty looping ring stops rather than spinning on scan_done
    if (pass_end) begin
      scan_done_d = 1'b1;
      if (scan_loop && !ring_empty) begin
        ptr_d = scan_first;
      end else begin
        scanning_d = 1'b0;
      end
    end
    if (scan_start) begin
      ptr_d      = scan_first;
      scanning_d = 1'b1;
      pt_valid_d = 1'b0;
    end else if (scan_abort) begin
      scanning_d = 1'b0;
      pt_valid_d = 1'b0;
    end
    if (scan_ctl && videnabb && own_scan_q && !cap) begin
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      armbusy_q   <= 1'b0;
      arm_pend_q  <= 1'b0;
      armaddr_q   <= 15'd0;
      armdata_q   <= 22'd0;
      armdone_q   <= 1'b0;
      scanning_q  <= 1'b0;
      scan_done_q <= 1'b0;
      pt_valid_q  <= 1'b0;
      pt_data_q   <= 22'd0;
      ptr_q       <= 15'd0;
      discard_q   <= 1'b0;
    end else begin
      armbusy_q   <= armbusy_d;
      arm_pend_q  <= arm_pend_d;
      armaddr_q   <= armaddr_d;
      armdata_q   <= armdata_d;
      armdone_q   <= armdone_d;
      scanning_q  <= scanning_d;
      scan_done_q <= scan_done_d;
      pt_valid_q  <= pt_valid_d;
      pt_data_q   <= pt_data_d;
      ptr_q       <= ptr_d;
      discard_q   <= discard_d;
    end
  end

  assign armbusy   = armbusy_q;
  assign armdone   = armdone_q;
  assign armdata   = armdata_q;
  assign scanning  = scanning_q;
  assign scan_done = scan_done_q;
  assign pt_valid  = pt_valid_q;
  assign pt_data   = pt_data_q;

endmodule
